// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// This block sits between the board pushbuttons/switches and an 8-bit ALU.
// It synchronises and debounces three pushbuttons. It turns each debounced
// press into a command:
//   pb1 : load operand A from sw
//   pb2 : load operand B from sw
//   pb3 : execute the opcode on sw[2:0]
// It sequences the ALU through a one-cycle execute strobe. It then captures
// the ALU's registered result and flags for the display front end.
//
// Parameters
//   WIDTH           operand/result width (must be >= 3)
//   DEBOUNCE_CYCLES consecutive stable synchronised samples before a
//                   button level is accepted
//
// Ports
//   clk_50M     in   system clock, rising edge
//   rst         in   asynchronous, active-low reset
//   pb1/pb2/pb3 in   raw pushbuttons (load A / load B / execute)
//   sw          in   operand value or opcode (sw[2:0])
//   alu_a       out  operand A register to ALU
//   alu_b       out  operand B register to ALU
//   alu_op      out  latched opcode to ALU
//   alu_en      out  one-cycle execute strobe to ALU
//   alu_result  in   ALU result, registered on the edge ending alu_en
//   alu_carry   in   ALU carry/borrow, same timing as alu_result
//   result      out  captured result
//   carry_flag  out  captured carry
//   zero_flag   out  captured (alu_result == 0)
//   err         out  last execute request carried an illegal opcode
//   busy        out  execute sequence in progress
//   done        out  one-cycle pulse when result/flags update
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk_50M,
   input  logic             rst,
   input  logic             pb1,
   input  logic             pb2,
   input  logic             pb3,
   input  logic [WIDTH-1:0] sw,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   output logic             alu_en,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry,
   output logic [WIDTH-1:0] result,
   output logic             carry_flag,
   output logic             zero_flag,
   output logic             err,
   output logic             busy,
   output logic             done
);

   localparam int NBTN  = 3;
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXEC    = 2'd1,
      S_CAPTURE = 2'd2
   } state_e;

   // -------------------------------------------------------------------------
   // Button path: 2-flop synchroniser, debounce counter, rising-edge detect.
   // Bit 0 = pb1, bit 1 = pb2, bit 2 = pb3.
   // -------------------------------------------------------------------------
   logic [NBTN-1:0]  btn_raw;
   logic [NBTN-1:0]  sync1_q;
   logic [NBTN-1:0]  sync2_q;
   logic [NBTN-1:0]  deb_q;
   logic [NBTN-1:0]  deb_prev_q;
   logic [CNT_W-1:0] cnt_q [NBTN];
   logic [NBTN-1:0]  press;

   assign btn_raw = {pb3, pb2, pb1};

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk_50M or negedge rst) begin
      if (!rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         for (int i = 0; i < NBTN; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q    <= btn_raw;
         sync2_q    <= sync1_q;
         deb_prev_q <= deb_q;
         for (int i = 0; i < NBTN; i++) begin
            // A single-bit level can only differ from the debounced level or
            // match it. Any glitch back to the old level therefore restarts
            // the count.
            if (sync2_q[i] == deb_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_MAX) begin
               cnt_q[i] <= '0;
               deb_q[i] <= sync2_q[i];
            end else begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // A press is the 0->1 transition of the debounced level. It lasts one cycle.
   assign press = deb_q & ~deb_prev_q;

   // Fixed priority pb1 > pb2 > pb3. Losers in the same cycle are dropped.
   logic ev_load_a;
   logic ev_load_b;
   logic ev_exec;

   assign ev_load_a = press[0];
   assign ev_load_b = press[1] & ~press[0];
   assign ev_exec   = press[2] & ~press[1] & ~press[0];

   // -------------------------------------------------------------------------
   // Control FSM and datapath registers
   // -------------------------------------------------------------------------
   state_e           state_q, state_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [2:0]       alu_op_q, alu_op_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             err_q, err_d;
   logic             done_q, done_d;
   logic             op_legal;

   // Opcodes 1..6 are ADD, SUB, NEG A, AND, OR, XOR. Opcodes 0 and 7 are unused.
   assign op_legal = (sw[2:0] != 3'd0) && (sw[2:0] != 3'd7);

   always_ff @(posedge clk_50M or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         alu_op_q <= alu_op_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         err_q    <= err_d;
         done_q   <= done_d;
      end
   end

   // NOTE: every signal gets a hold/default value before the case statement.
   // No path can then leave a signal unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      alu_op_d = alu_op_q;
      result_d = result_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      err_d    = err_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (ev_load_a) begin
               alu_a_d = sw;
               err_d   = 1'b0;
            end else if (ev_load_b) begin
               alu_b_d = sw;
               err_d   = 1'b0;
            end else if (ev_exec) begin
               if (op_legal) begin
                  alu_op_d = sw[2:0];
                  err_d    = 1'b0;
                  state_d  = S_EXEC;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         // alu_en is decoded from this state. The ALU registers its result
         // on the edge that leaves it.
         S_EXEC: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            result_d = alu_result;
            carry_d  = alu_carry;
            zero_d   = (alu_result == '0);
            done_d   = 1'b1;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_op     = alu_op_q;
   assign alu_en     = (state_q == S_EXEC);
   assign result     = result_q;
   assign carry_flag = carry_q;
   assign zero_flag  = zero_q;
   assign err        = err_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Directed bench for alu_op_sequencer. A small registered ALU model answers
// the execute strobe. Every expected value below is hand-computed.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

   localparam int WIDTH = 8;
   localparam int DEB   = 4;
   localparam int HOLD  = 12;   // cycles a button is held high or low

   logic             clk_50M;
   logic             rst;
   logic [2:0]       pb_vec;     // {pb3, pb2, pb1}
   logic [WIDTH-1:0] sw;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_op;
   logic             alu_en;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;
   logic [WIDTH-1:0] result;
   logic             carry_flag;
   logic             zero_flag;
   logic             err;
   logic             busy;
   logic             done;

   int checks = 0;
   int errors = 0;
   int en_count = 0;
   int done_count = 0;

   alu_op_sequencer #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk_50M    (clk_50M),
      .rst        (rst),
      .pb1        (pb_vec[0]),
      .pb2        (pb_vec[1]),
      .pb3        (pb_vec[2]),
      .sw         (sw),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_en     (alu_en),
      .alu_result (alu_result),
      .alu_carry  (alu_carry),
      .result     (result),
      .carry_flag (carry_flag),
      .zero_flag  (zero_flag),
      .err        (err),
      .busy       (busy),
      .done       (done)
   );

   initial clk_50M = 1'b0;
   always #10 clk_50M = ~clk_50M;

   // Behavioural ALU that registers its result on the edge ending alu_en.
   // SUB and NEG report borrow in carry.
   initial begin
      alu_result = '0;
      alu_carry  = 1'b0;
   end
   always @(posedge clk_50M) begin
      if (alu_en) begin
         case (alu_op)
            3'd1: {alu_carry, alu_result} <= {1'b0, alu_a} + {1'b0, alu_b};
            3'd2: {alu_carry, alu_result} <= {1'b0, alu_a} - {1'b0, alu_b};
            3'd3: {alu_carry, alu_result} <= 9'd0 - {1'b0, alu_a};
            3'd4: {alu_carry, alu_result} <= {1'b0, alu_a & alu_b};
            3'd5: {alu_carry, alu_result} <= {1'b0, alu_a | alu_b};
            3'd6: {alu_carry, alu_result} <= {1'b0, alu_a ^ alu_b};
            default: {alu_carry, alu_result} <= 9'd0;
         endcase
      end
   end

   always @(negedge clk_50M) begin
      if (alu_en) en_count++;
      if (done)   done_count++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Hold the selected buttons high, then release them. Each phase is long
   // enough to be debounced.
   task automatic press(input logic [2:0] mask, input logic [7:0] val);
      sw = val;
      pb_vec = mask;
      repeat (HOLD) @(negedge clk_50M);
      pb_vec = 3'b000;
      repeat (HOLD) @(negedge clk_50M);
   endtask

   // Run one execute and check the alu_en / busy / done timing and the
   // captured result. When pb1_delay >= 0, pb1 is raised that many cycles
   // after pb3, so its event lands inside the busy window.
   task automatic exec_op(input string name, input logic [7:0] sw_val, input int pb1_delay,
                          input logic [7:0] exp_res, input logic exp_c, input logic exp_z);
      logic found;
      int   d0;
      sw = sw_val;
      pb_vec[2] = 1'b1;
      if (pb1_delay >= 0) begin
         repeat (pb1_delay) @(negedge clk_50M);
         pb_vec[0] = 1'b1;
      end
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk_50M);
         if (alu_en) found = 1'b1;
      end
      d0 = done_count;
      check({name, "_en_seen"}, 64'(found), 64'd1);
      check({name, "_busy_exec"}, 64'(busy), 64'd1);
      @(negedge clk_50M);
      check({name, "_en_1cyc"}, 64'(alu_en), 64'd0);
      check({name, "_busy_cap"}, 64'(busy), 64'd1);
      check({name, "_done_early"}, 64'(done), 64'd0);
      @(negedge clk_50M);
      check({name, "_done"}, 64'(done), 64'd1);
      check({name, "_busy_end"}, 64'(busy), 64'd0);
      check({name, "_result"}, 64'(result), 64'(exp_res));
      check({name, "_carry"}, 64'(carry_flag), 64'(exp_c));
      check({name, "_zero"}, 64'(zero_flag), 64'(exp_z));
      @(negedge clk_50M);
      check({name, "_done_1cyc"}, 64'(done), 64'd0);
      pb_vec = 3'b000;
      repeat (HOLD) @(negedge clk_50M);
      check({name, "_done_count"}, 64'(done_count - d0), 64'd1);
   endtask

   initial begin
      int   en0;
      int   dn0;
      logic found;

      rst    = 1'b0;
      pb_vec = 3'b000;
      sw     = '0;
      repeat (3) @(negedge clk_50M);
      check("reset_outputs",
            64'({alu_a, alu_b, alu_op, alu_en, result, carry_flag, zero_flag, err, busy, done}),
            64'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk_50M);

      // Load operands and ADD.
      press(3'b001, 8'hFF);
      check("load_a", 64'(alu_a), 64'hFF);
      press(3'b010, 8'h0F);
      check("load_b", 64'(alu_b), 64'h0F);
      check("load_b_keeps_a", 64'(alu_a), 64'hFF);
      exec_op("add", 8'h01, -1, 8'h0E, 1'b1, 1'b0);
      check("add_op", 64'(alu_op), 64'd1);

      // Opcode sweep with A=FF, B=0F.
      exec_op("sub", 8'h02, -1, 8'hF0, 1'b0, 1'b0);
      exec_op("neg", 8'h03, -1, 8'h01, 1'b1, 1'b0);
      exec_op("and", 8'h04, -1, 8'h0F, 1'b0, 1'b0);
      exec_op("or",  8'h05, -1, 8'hFF, 1'b0, 1'b0);
      exec_op("xor", 8'hFE, -1, 8'hF0, 1'b0, 1'b0);   // sw[7:3] ignored

      press(3'b001, 8'hF0);
      exec_op("and_zero", 8'h04, -1, 8'h00, 1'b0, 1'b1);

      // Bounce rejection on press and on release.
      sw = 8'h11;
      for (int k = 0; k < 5; k++) begin
         pb_vec[0] = 1'b1; repeat (2) @(negedge clk_50M);
         pb_vec[0] = 1'b0; repeat (2) @(negedge clk_50M);
      end
      repeat (HOLD) @(negedge clk_50M);
      check("bounce_no_load", 64'(alu_a), 64'hF0);
      sw = 8'h5A;
      pb_vec[0] = 1'b1;
      repeat (HOLD) @(negedge clk_50M);
      check("bounce_stable_load", 64'(alu_a), 64'h5A);
      sw = 8'h77;
      for (int k = 0; k < 5; k++) begin
         pb_vec[0] = 1'b0; repeat (2) @(negedge clk_50M);
         pb_vec[0] = 1'b1; repeat (2) @(negedge clk_50M);
      end
      pb_vec[0] = 1'b0;
      repeat (HOLD) @(negedge clk_50M);
      check("bounce_release_no_load", 64'(alu_a), 64'h5A);

      // Same-cycle pb1 and pb2: only A is loaded.
      press(3'b011, 8'h3C);
      check("prio_a", 64'(alu_a), 64'h3C);
      check("prio_b_kept", 64'(alu_b), 64'h0F);

      // pb1 events during EXEC and CAPTURE are discarded. 3C | 0F = 3F.
      exec_op("busy_exec", 8'h05, 1, 8'h3F, 1'b0, 1'b0);
      check("busy_exec_a_kept", 64'(alu_a), 64'h3C);
      exec_op("busy_cap", 8'h05, 2, 8'h3F, 1'b0, 1'b0);
      check("busy_cap_a_kept", 64'(alu_a), 64'h3C);

      // Illegal opcodes 0 and 7.
      en0 = en_count;
      dn0 = done_count;
      press(3'b100, 8'h00);
      check("ill0_err", 64'(err), 64'd1);
      press(3'b100, 8'h07);
      check("ill7_err", 64'(err), 64'd1);
      check("ill_no_en", 64'(en_count - en0), 64'd0);
      check("ill_no_done", 64'(done_count - dn0), 64'd0);
      check("ill_result_kept", 64'(result), 64'h3F);
      check("ill_op_kept", 64'(alu_op), 64'd5);
      exec_op("after_ill", 8'h06, -1, 8'h33, 1'b0, 1'b0);
      check("after_ill_err", 64'(err), 64'd0);

      // Reset during EXEC aborts the sequence.
      sw = 8'h01;
      pb_vec[2] = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk_50M);
         if (alu_en) found = 1'b1;
      end
      check("rstmid_en_seen", 64'(found), 64'd1);
      rst = 1'b0;
      #1;
      check("rstmid_outputs",
            64'({alu_a, alu_b, alu_op, alu_en, result, carry_flag, zero_flag, err, busy, done}),
            64'd0);
      en0 = en_count;
      dn0 = done_count;
      pb_vec = 3'b000;
      repeat (4) @(negedge clk_50M);
      rst = 1'b1;
      repeat (HOLD + 8) @(negedge clk_50M);
      check("rstmid_no_en", 64'(en_count - en0), 64'd0);
      check("rstmid_no_done", 64'(done_count - dn0), 64'd0);
      check("rstmid_result", 64'(result), 64'd0);
      press(3'b001, 8'hA5);
      check("rstmid_load_a", 64'(alu_a), 64'hA5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
